axis_pixel_tx: RTL

AXIS_PIXEL_TX -- requirements
Module: axis_pixel_tx

---
 rtl/axis_pixel_pkg.sv | 18 +
 rtl/axis_pixel_fifo.sv | 61 ++++++
 rtl/axis_pixel_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/axis_pixel_pkg.sv
// Shared types and constants for the axis_pixel_tx AXI4-Stream pixel transmitter.
package axis_pixel_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_LEN_WIDTH  = 16;

  // Wide enough for TDATA up to 1024 bits; the top slices off what it needs.
  localparam int                        MAX_STRB_WIDTH = 128;
  localparam logic [MAX_STRB_WIDTH-1:0] TSTRB_ALL_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

endpackage : axis_pixel_pkg

// File: rtl/axis_pixel_fifo.sv
// Synchronous show-ahead FIFO buffering pixel words for axis_pixel_tx.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module axis_pixel_fifo
  import axis_pixel_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      pop,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      empty
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]    ONE     = (AW+1)'(1);

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  push_ok;
  logic                  pop_ok;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule : axis_pixel_fifo

// File: rtl/axis_pixel_tx.sv
// Packetising AXI4-Stream pixel transmitter: FIFO-buffered words sent as pkt_len-beat packets.
// Define AXIS_PIXEL_TX_SOF_USER_EN to add M_AXIS_TUSER, flagging the first beat of each packet.
module axis_pixel_tx
  import axis_pixel_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          enable,
  input  logic [LEN_WIDTH-1:0]          pkt_len,
  input  logic                          wr_valid,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          wr_ready,
  output logic                          M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]         M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0]       M_AXIS_TSTRB,
  output logic                          M_AXIS_TLAST,
`ifdef AXIS_PIXEL_TX_SOF_USER_EN
  output logic                          M_AXIS_TUSER,
`endif
  input  logic                          M_AXIS_TREADY,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   pkt_count,
  output logic                          busy
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [31:0]           pkt_count_q, pkt_count_d;
  logic                  rdy_en_q;

  logic                  fifo_push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  logic                  tvalid;
  logic                  last_beat;
  logic                  beat_fire;
  logic                  last_fire;
  logic                  pkt_start;
  logic [LEN_WIDTH-1:0]  pkt_len_eff;

  axis_pixel_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .push    (fifo_push),
    .wr_data (wr_data),
    .pop     (beat_fire),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // wr_ready stays low through reset and rises on the first clock edge after release.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rdy_en_q <= 1'b0;
    else          rdy_en_q <= 1'b1;
  end

  assign wr_ready  = rdy_en_q && !fifo_full;
  assign fifo_push = wr_valid && wr_ready;

  assign last_beat   = (beat_q == len_q - LEN_ONE);
  assign beat_fire   = tvalid && M_AXIS_TREADY;
  assign last_fire   = beat_fire && last_beat;
  assign pkt_len_eff = (pkt_len == '0) ? LEN_ONE : pkt_len;
  // A new packet starts either from IDLE or straight after a last beat while enable holds.
  assign pkt_start   = ((state_q == ST_IDLE) && enable && !fifo_empty) ||
                       (last_fire && enable);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (enable && !fifo_empty)  state_d = ST_STREAM;
      ST_STREAM: if (last_fire && !enable)   state_d = ST_HOLD;
      ST_HOLD:                               state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tvalid        = (state_q == ST_STREAM) && !fifo_empty;
    busy          = (state_q != ST_IDLE);
    M_AXIS_TVALID = tvalid;
    M_AXIS_TDATA  = tvalid ? fifo_rd_data : '0;
    M_AXIS_TLAST  = tvalid && last_beat;
`ifdef AXIS_PIXEL_TX_SOF_USER_EN
    M_AXIS_TUSER  = tvalid && (beat_q == '0);
`endif
  end

  assign M_AXIS_TSTRB = TSTRB_ALL_ONES[DATA_WIDTH/8-1:0];

  always_comb begin
    len_d       = len_q;
    beat_d      = beat_q;
    pkt_count_d = pkt_count_q;
    if (beat_fire) beat_d      = beat_q + LEN_ONE;
    if (last_fire) pkt_count_d = pkt_count_q + 32'd1;
    // pkt_len is only looked at here, so mid-packet changes cannot resize a packet.
    if (pkt_start) begin
      len_d  = pkt_len_eff;
      beat_d = '0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      len_q       <= LEN_ONE;
      beat_q      <= '0;
      pkt_count_q <= '0;
    end else begin
      len_q       <= len_d;
      beat_q      <= beat_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;

endmodule : axis_pixel_tx
